// File: rtl/ae_pkg.sv
// Shared types and constants for the autoencoder layer datapath.
package ae_pkg;

    localparam int DATA_W  = 16;
    localparam int N_WORDS = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic signed [DATA_W-1:0] word_t;

endpackage

// File: rtl/layer_serializer_if.sv
// Vector-in / word-out bus of the layer serializer.
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// valid never waits for ready, and the payload holds stable while valid is high and ready is low.
interface layer_serializer_if;
    import ae_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W*N_WORDS-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    word_t                     out_data;
    logic [SEL_W-1:0]          out_index;
    logic                      out_last;
    logic                      frame_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, frame_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, frame_done
    );

endinterface

// File: rtl/layer_serializer_mux.sv
// 16:1 word multiplexer; input_1 is selected by select == 0.
module mux_16_1 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [WIDTH-1:0] input_3,
    input  logic [WIDTH-1:0] input_4,
    input  logic [WIDTH-1:0] input_5,
    input  logic [WIDTH-1:0] input_6,
    input  logic [WIDTH-1:0] input_7,
    input  logic [WIDTH-1:0] input_8,
    input  logic [WIDTH-1:0] input_9,
    input  logic [WIDTH-1:0] input_10,
    input  logic [WIDTH-1:0] input_11,
    input  logic [WIDTH-1:0] input_12,
    input  logic [WIDTH-1:0] input_13,
    input  logic [WIDTH-1:0] input_14,
    input  logic [WIDTH-1:0] input_15,
    input  logic [WIDTH-1:0] input_16,
    input  logic [3:0]       select,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = input_1;
        case (select)
            4'd0:  result = input_1;
            4'd1:  result = input_2;
            4'd2:  result = input_3;
            4'd3:  result = input_4;
            4'd4:  result = input_5;
            4'd5:  result = input_6;
            4'd6:  result = input_7;
            4'd7:  result = input_8;
            4'd8:  result = input_9;
            4'd9:  result = input_10;
            4'd10: result = input_11;
            4'd11: result = input_12;
            4'd12: result = input_13;
            4'd13: result = input_14;
            4'd14: result = input_15;
            4'd15: result = input_16;
            default: result = input_1;
        endcase
    end

endmodule

// File: rtl/layer_serializer.sv
// Captures a 16-word neuron vector and streams it out one word per beat, index 0 first.
// Optional ReLU on the output word: define LAYER_SERIALIZER_RELU_EN.
module layer_serializer
    import ae_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int N_WORDS = 16
) (
    input  logic                clk,
    input  logic                rst,
    layer_serializer_if.slave   bus,
    output state_t              dbg_state
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_WORDS - 1);

    if (DATA_W != ae_pkg::DATA_W || N_WORDS != ae_pkg::N_WORDS) begin : g_bad_cfg
        $error("layer_serializer: DATA_W and N_WORDS are fixed to 16 by the 16:1 mux");
    end

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] count;
    word_t            vec [N_WORDS];
    logic             done_q;
    logic             in_ready_int;
    logic             out_valid_int;
    logic             fire_in;
    logic             fire_out;
    logic             last_beat;
    logic [DATA_W-1:0] mux_word;

    // in_ready is also masked by rst so nothing can be captured on the reset edge.
    assign in_ready_int  = (state == IDLE) && !rst;
    assign out_valid_int = (state == SEND);
    assign fire_in       = bus.in_valid && in_ready_int;
    assign fire_out      = out_valid_int && bus.out_ready;
    assign last_beat     = fire_out && (count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            done_q <= 1'b0;
            for (int k = 0; k < N_WORDS; k++) begin
                vec[k] <= '0;
            end
        end else begin
            state  <= state_next;
            done_q <= last_beat;
            if (fire_in) begin
                count <= '0;
                for (int k = 0; k < N_WORDS; k++) begin
                    vec[k] <= word_t'(bus.in_data[k*DATA_W +: DATA_W]);
                end
            end else if (fire_out) begin
                count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fire_in)   state_next = SEND;
            SEND:    if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    mux_16_1 #(
        .WIDTH (DATA_W)
    ) u_mux (
        .input_1  (vec[0]),
        .input_2  (vec[1]),
        .input_3  (vec[2]),
        .input_4  (vec[3]),
        .input_5  (vec[4]),
        .input_6  (vec[5]),
        .input_7  (vec[6]),
        .input_8  (vec[7]),
        .input_9  (vec[8]),
        .input_10 (vec[9]),
        .input_11 (vec[10]),
        .input_12 (vec[11]),
        .input_13 (vec[12]),
        .input_14 (vec[13]),
        .input_15 (vec[14]),
        .input_16 (vec[15]),
        .select   (count),
        .result   (mux_word)
    );

    always_comb begin
        bus.in_ready   = in_ready_int;
        bus.out_valid  = out_valid_int;
        bus.out_index  = count;
        bus.out_last   = out_valid_int && (count == LAST_IDX);
        bus.frame_done = done_q;
`ifdef LAYER_SERIALIZER_RELU_EN
        bus.out_data   = mux_word[DATA_W-1] ? '0 : word_t'(mux_word);
`else
        bus.out_data   = word_t'(mux_word);
`endif
        dbg_state      = state;
    end

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer: captures push 16 expected beats, accepted beats pop them.
module tb_layer_serializer;
    import ae_pkg::*;

    localparam int W = 21;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    layer_serializer_if bus ();

    layer_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic fd_exp     = 1'b0;
    int   cycle      = 0;
    int   accepted   = 0;
    int   captures   = 0;
    int   last_cap   = 0;
    int   fd_cycle   = 0;
    bit   gap_mode   = 1'b0;
    bit   gap_ref    = 1'b0;
    bit   bp_mode    = 1'b0;
    bit   iso_mode   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [15:0] w);
`ifdef LAYER_SERIALIZER_RELU_EN
        return w[15] ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'($urandom_range(0, 65535));
        return v;
    endfunction

    // Monitor + scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic fd_next;
        cycle++;
        fd_next = 1'b0;
        if (rst) begin
            check("in_ready_in_rst", bus.in_ready, 1'b0);
            exp_q.delete();
            fd_exp = 1'b0;
        end else begin
            check("frame_done", bus.frame_done, fd_exp);
            if (fd_exp) fd_cycle = cycle;
            check("out_valid", bus.out_valid, exp_q.size() != 0);
            check("in_ready", bus.in_ready, exp_q.size() == 0);
            if (exp_q.size() != 0) begin
                check("beat", {bus.out_last, bus.out_index, bus.out_data}, exp_q[0]);
                if (bus.out_ready) begin
                    fd_next = exp_q[0][20];
                    void'(exp_q.pop_front());
                    accepted++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (gap_mode && gap_ref) check("capture_interval", cycle - last_cap, 17);
                gap_ref  = 1'b1;
                last_cap = cycle;
                captures++;
                for (int k = 0; k < 16; k++)
                    exp_q.push_back({(k == 15), 4'(k), model_word(bus.in_data[k*16 +: 16])});
            end
            fd_exp = fd_next;
        end
    end

    task automatic send_vec(input logic [255:0] v);
        int c0;
        bit ok;
        c0 = captures;
        ok = 1'b0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (captures != c0) begin
                ok = 1'b1;
                break;
            end
        end
        check("capture_timeout", ok, 1'b1);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (bp_mode) bus.out_ready = ~bus.out_ready;
            if (iso_mode) bus.in_data = rand_vec();
            if (exp_q.size() == 0 && !fd_exp) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", ok, 1'b1);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        logic [255:0] v;
        int c0;
        int base;
        bit ok;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1;

        // Basic stream: words 0x0100 + k.
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'h0100 + 16'(k);
        send_vec(v);
        wait_idle();
        check("done_latency", fd_cycle - last_cap, 17);

        // Backpressure: out_ready low every second cycle.
        bp_mode = 1'b1;
        send_vec(rand_vec());
        wait_idle();
        bp_mode = 1'b0;

        // Input isolation: in_valid held with changing data during SEND.
        gap_mode = 1'b1;
        gap_ref  = 1'b0;
        c0 = captures;
        send_vec(rand_vec());
        bus.in_valid = 1'b1;
        iso_mode = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 bus.in_data = rand_vec();
            if (captures >= c0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("iso_second_capture", ok, 1'b1);
        bus.in_valid = 1'b0;
        iso_mode = 1'b0;
        wait_idle();
        gap_mode = 1'b0;

        // ReLU pattern: 8001 / 7FFF alternating.
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = (k % 2 == 0) ? 16'h8001 : 16'h7FFF;
        send_vec(v);
        wait_idle();

        // Reset after word 5 is accepted.
        base = accepted;
        send_vec(rand_vec());
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (accepted >= base + 6) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_rst_reach_word5", ok, 1'b1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_frame_done", bus.frame_done, 1'b0);
        @(posedge clk);
        #1;
        send_vec(rand_vec());
        wait_idle();

        // Back-to-back vectors with in_valid held high.
        gap_mode = 1'b1;
        gap_ref  = 1'b0;
        c0 = captures;
        bus.in_data  = rand_vec();
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            int cb;
            cb = captures;
            @(posedge clk);
            if (captures >= c0 + 3) begin
                ok = 1'b1;
                break;
            end
            if (captures != cb) #1 bus.in_data = rand_vec();
        end
        check("b2b_captures", ok, 1'b1);
        #1 bus.in_valid = 1'b0;
        wait_idle();
        gap_mode = 1'b0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
